// File: rtl/acc_sum_sequencer.sv
// Accelerator-side sequencer: streams NUM_LINES cache lines as reads, sums every
// 32-bit lane of the returned data and writes the 32-bit total to a destination line.
module acc_sum_sequencer #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 256,
    parameter int LEN_W     = 16,
    parameter int MAX_OUT   = 4,
    parameter int ADDR_STEP = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  num_lines_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       sum_o,
    output logic              err_o,
    output logic              mem_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [31:0]       mem_wstrb_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int LANES = DATA_W / 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  num_lines;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  returned;
    logic [LEN_W-1:0]  returned_next;
    logic [OUT_W-1:0]  outstanding;
    logic [31:0]       acc;
    logic [31:0]       line_sum;
    logic              in_return;
    logic              rd_accept;
    logic              ret_ok;
    logic              ret_spurious;

    always_comb begin
        line_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            line_sum = line_sum + mem_rdata_i[32*i +: 32];
        end
    end

    assign busy_o        = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_WRITE);
    assign done_o        = (state == S_DONE);
    assign in_return     = (state == S_ISSUE) || (state == S_DRAIN);
    assign rd_accept     = (state == S_ISSUE) && mem_valid_o && mem_ready_i;
    assign ret_ok        = in_return && mem_rvalid_i && (outstanding != '0);
    assign ret_spurious  = busy_o && mem_rvalid_i && (outstanding == '0);
    assign returned_next = returned + LEN_W'(ret_ok);

    // Request outputs are pure decodes of registered state, so a raised request
    // cannot change until it is accepted: only an accept moves issued/rd_addr.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        mem_valid_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        case (state)
            S_ISSUE: begin
                mem_valid_o = (issued < num_lines) && (outstanding < OUT_W'(MAX_OUT));
                mem_addr_o  = rd_addr;
            end
            S_WRITE: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = dst_addr;
                mem_wdata_o = DATA_W'(acc);
                mem_wstrb_o = 32'h0000_000F;
            end
            default: ;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            rd_addr     <= '0;
            dst_addr    <= '0;
            num_lines   <= '0;
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
            acc         <= '0;
            sum_o       <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        rd_addr     <= base_addr_i;
                        dst_addr    <= dst_addr_i;
                        num_lines   <= num_lines_i;
                        issued      <= '0;
                        returned    <= '0;
                        outstanding <= '0;
                        acc         <= '0;
                        err_o       <= 1'b0;
                        state       <= (num_lines_i == '0) ? S_WRITE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (rd_accept) begin
                        issued  <= issued + LEN_W'(1);
                        rd_addr <= rd_addr + ADDR_W'(ADDR_STEP);
                        if (issued + LEN_W'(1) == num_lines) state <= S_DRAIN;
                    end
                end
                // Counting the return of this very cycle lets the write follow the last rvalid directly.
                S_DRAIN: if (returned_next == num_lines) state <= S_WRITE;
                S_WRITE: begin
                    if (mem_ready_i) begin
                        sum_o <= acc;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (ret_ok) begin
                acc      <= acc + line_sum;
                returned <= returned_next;
            end
            if (ret_spurious) err_o <= 1'b1;

            if (rd_accept && !ret_ok) outstanding <= outstanding + OUT_W'(1);
            else if (!rd_accept && ret_ok) outstanding <= outstanding - OUT_W'(1);
        end
    end
endmodule

// File: tb/tb_acc_sum_sequencer.sv
// Randomized self-checking bench for acc_sum_sequencer: a queue-based memory model
// returns read data in order and a lane-total model predicts the written sum.
module tb_acc_sum_sequencer;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 256;
    localparam int LEN_W     = 16;
    localparam int MAX_OUT   = 4;
    localparam int ADDR_STEP = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [LEN_W-1:0]  num_lines_i;
    logic [ADDR_W-1:0] dst_addr_i;
    logic              busy_o;
    logic              done_o;
    logic [31:0]       sum_o;
    logic              err_o;
    logic              mem_valid_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [31:0]       mem_wstrb_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_rvalid_i;

    acc_sum_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT), .ADDR_STEP(ADDR_STEP)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .num_lines_i(num_lines_i), .dst_addr_i(dst_addr_i),
        .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o), .err_o(err_o),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .mem_rvalid_i(mem_rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        logic [255:0] data;
    } resp_t;

    resp_t rq[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // 1: lanes 1..8, 2: all lanes 1, 3: all lanes 0xFFFFFFFF, else random
    function automatic logic [255:0] gen_line(input int mode);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                1:       d[32*i +: 32] = 32'(i + 1);
                2:       d[32*i +: 32] = 32'd1;
                3:       d[32*i +: 32] = 32'hFFFF_FFFF;
                default: d[32*i +: 32] = $urandom;
            endcase
        end
        return d;
    endfunction

    // Exact (unwrapped) lane total; the 32-bit result is taken only at the end.
    function automatic longint unsigned lanes_total(input logic [255:0] d);
        longint unsigned s = 0;
        for (int i = 0; i < 8; i++) s += longint'(d[32*i +: 32]);
        return s;
    endfunction

    task automatic drive_ret(input int c, output logic [255:0] d, output bit hit);
        hit          = 1'b0;
        d            = '0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = gen_line(0);
        if (rq.size() > 0 && rq[0].due == c) begin
            hit          = 1'b1;
            d            = rq[0].data;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = d;
            void'(rq.pop_front());
        end
    endtask

    // lat: fixed read latency (>0) or random 1..4 (0); rdy_mode: 0 always ready,
    // 1 random, 2 five stall cycles on the second read.
    task automatic run_cmd(input logic [ADDR_W-1:0] base, input int n, input logic [ADDR_W-1:0] dst,
                           input int lat, input int rdy_mode, input int data_mode,
                           input bit spur, input bit dup_start, input int rst_after,
                           input bit chk_lat, input int exp_peak);
        longint unsigned   total = 0;
        int                accepted = 0, done_cyc = -1, first_valid = -1, peak = 0;
        int                stall = 0, last_due = 0, pend, due_c, c;
        bit                prev_hold = 1'b0, hit;
        logic [ADDR_W-1:0] prev_addr = '0, exp_addr;
        logic [255:0]      d;

        rq.delete();
        start_i      = 1'b1;
        base_addr_i  = base;
        num_lines_i  = LEN_W'(n);
        dst_addr_i   = dst;
        mem_ready_i  = 1'b1;
        mem_rvalid_i = 1'b0;
        step();
        for (c = 1; c < n * 12 + 40; c++) begin
            start_i = 1'b0;
            if (dup_start && c == 3) begin
                start_i     = 1'b1;
                base_addr_i = 19'h1234;
                num_lines_i = 16'd7;
                dst_addr_i  = 19'h4321;
            end

            if (rst_after >= 0 && accepted == rst_after) begin
                rst_ni      = 1'b0;
                mem_ready_i = 1'b0;
                drive_ret(c, d, hit);
                step();
                c++;
                rst_ni = 1'b1;
                check("rst_busy", busy_o, 0);
                check("rst_done", done_o, 0);
                check("rst_err", err_o, 0);
                check("rst_valid", mem_valid_o, 0);
                check("rst_addr", mem_addr_o, 0);
                check("rst_wdata", mem_wdata_o, 0);
                check("rst_wstrb", mem_wstrb_o, 0);
                check("rst_sum", sum_o, 0);
                while (rq.size() > 0 && c < 400) begin
                    drive_ret(c, d, hit);
                    step();
                    c++;
                end
                mem_rvalid_i = 1'b0;
                step();
                check("rst_late_err", err_o, 0);
                check("rst_late_busy", busy_o, 0);
                return;
            end

            pend = rq.size();
            drive_ret(c, d, hit);
            if (hit) total += lanes_total(d);
            if (spur && c == 1) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = gen_line(3);
            end

            case (rdy_mode)
                1: mem_ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    mem_ready_i = !(mem_valid_o && accepted == 1 && stall < 5);
                    if (!mem_ready_i) stall++;
                end
                default: mem_ready_i = 1'b1;
            endcase

            if (c == 1) check("busy_run", busy_o, 1);
            if (prev_hold) begin
                check("hold_valid", mem_valid_o, 1);
                check("hold_addr", mem_addr_o, prev_addr);
            end
            prev_hold = mem_valid_o && !mem_ready_i;
            prev_addr = mem_addr_o;
            if (pend == MAX_OUT) check("full_stall", mem_valid_o, 0);
            if (mem_valid_o && first_valid < 0) first_valid = c;

            if (mem_valid_o && mem_ready_i) begin
                if (mem_wstrb_o == 32'h0) begin
                    exp_addr = ADDR_W'(int'(base) + accepted * ADDR_STEP);
                    check("rd_addr", mem_addr_o, exp_addr);
                    check("rd_count", accepted < n, 1);
                    if (pend + 1 > peak) peak = pend + 1;
                    due_c = c + ((lat > 0) ? lat : int'($urandom_range(1, 4)));
                    if (due_c <= last_due) due_c = last_due + 1;
                    rq.push_back('{due: due_c, data: gen_line(data_mode)});
                    last_due = due_c;
                    accepted++;
                end else begin
                    check("wr_addr", mem_addr_o, dst);
                    check("wr_strb", mem_wstrb_o, 32'h0000_000F);
                    check("wr_data", mem_wdata_o, {224'b0, total[31:0]});
                    check("wr_all_read", accepted, n);
                    check("wr_all_back", rq.size(), 0);
                end
            end

            if (done_o) begin
                done_cyc = c;
                break;
            end
            step();
        end

        check("done_seen", done_cyc >= 0, 1);
        if (done_cyc >= 0) begin
            check("done_busy", busy_o, 0);
            check("sum", sum_o, total[31:0]);
            check("err", err_o, spur);
            if (chk_lat) begin
                check("lat_first_valid", first_valid, 1);
                check("lat_done", done_cyc, (n == 0) ? 2 : n + 3);
            end
            if (exp_peak >= 0) check("peak_out", peak, exp_peak);
            if (rdy_mode == 2) check("bp_stalls", stall, 5);
            mem_rvalid_i = 1'b0;
            mem_ready_i  = 1'b1;
            step();
            check("done_pulse", done_o, 0);
            check("sum_hold", sum_o, total[31:0]);
        end else begin
            rst_ni = 1'b0;
            step();
            rst_ni = 1'b1;
            step();
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        base_addr_i  = '0;
        num_lines_i  = '0;
        dst_addr_i   = '0;
        mem_ready_i  = 1'b0;
        mem_rdata_i  = '0;
        mem_rvalid_i = 1'b0;
        repeat (2) step();
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_err", err_o, 0);
        check("reset_valid", mem_valid_o, 0);
        check("reset_addr", mem_addr_o, 0);
        check("reset_wdata", mem_wdata_o, 0);
        check("reset_wstrb", mem_wstrb_o, 0);
        check("reset_sum", sum_o, 0);
        rst_ni = 1'b1;
        step();

        run_cmd(19'h100, 1, 19'h800, 1, 0, 1, 0, 0, -1, 1, -1);
        check("single_sum36", sum_o, 36);
        run_cmd(19'h100, 5, 19'h820, 1, 0, 0, 0, 0, -1, 1, -1);
        run_cmd(19'h100, 16, 19'h840, 3, 0, 2, 0, 0, -1, 0, -1);
        check("stream_sum128", sum_o, 128);
        run_cmd(19'h200, 16, 19'h860, 5, 0, 0, 0, 0, -1, 0, MAX_OUT);
        run_cmd(19'h100, 4, 19'h880, 1, 2, 0, 0, 0, -1, 0, -1);
        run_cmd(19'h300, 2, 19'h8A0, 1, 0, 3, 0, 0, -1, 0, -1);
        check("wrap_sum", sum_o, 32'hFFFF_FFF0);
        run_cmd(19'h7FFE0, 2, 19'h8C0, 1, 0, 0, 0, 0, -1, 0, -1);
        run_cmd(19'h100, 0, 19'h8E0, 1, 0, 0, 0, 0, -1, 1, -1);
        check("zero_sum", sum_o, 0);
        run_cmd(19'h400, 6, 19'h900, 2, 0, 0, 0, 1, -1, 0, -1);
        run_cmd(19'h500, 3, 19'h920, 2, 0, 0, 1, 0, -1, 0, -1);
        run_cmd(19'h500, 2, 19'h940, 1, 0, 1, 0, 0, -1, 0, -1);
        run_cmd(19'h600, 8, 19'h960, 3, 0, 0, 0, 0, 3, 0, -1);
        run_cmd(19'h600, 8, 19'h980, 3, 0, 1, 0, 0, -1, 0, -1);
        check("post_reset_sum", sum_o, 288);

        for (int k = 0; k < 12; k++) begin
            run_cmd(ADDR_W'($urandom), int'($urandom_range(0, 20)), ADDR_W'($urandom),
                    0, 1, 0, 0, 0, -1, 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
